// File: rtl/equeue_pkg.sv
// Shared defaults and helpers for the generic issue queue.
package equeue_pkg;

    localparam int unsigned DEF_DEPTH  = 4;
    localparam int unsigned DEF_TAG_W  = 6;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_N_CDB  = 2;
    localparam int unsigned DEF_AFULL  = 1;

    // Entry field widths for the default configuration.
    localparam int unsigned ENT_TAG_W  = DEF_TAG_W;
    localparam int unsigned ENT_DATA_W = DEF_DATA_W;

    // Ceiling log2, minimum result 0 (clog2(1) = 0).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned x = v - 1; x > 0; x = x >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/equeue_if.sv
// Dispatch / CDB / issue bundle between the queue and its neighbours.
interface equeue_if
    import equeue_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned TAG_W  = DEF_TAG_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned N_CDB  = DEF_N_CDB
);
    localparam int unsigned CNT_W = clog2(DEPTH + 1);

    logic                    flush;
    logic                    dispatch_en;
    logic [TAG_W-1:0]        dispatch_rdtag;
    logic [TAG_W-1:0]        dispatch_rstag;
    logic [TAG_W-1:0]        dispatch_rttag;
    logic [DATA_W-1:0]       dispatch_rsdata;
    logic [DATA_W-1:0]       dispatch_rtdata;
    logic                    dispatch_rsvalid;
    logic                    dispatch_rtvalid;
    logic                    dispatch_ready;
    logic [N_CDB*TAG_W-1:0]  cdb_tag;
    logic [N_CDB*DATA_W-1:0] cdb_data;
    logic [N_CDB-1:0]        cdb_valid;
    logic [TAG_W-1:0]        issue_rdtag;
    logic [DATA_W-1:0]       issue_rsdata;
    logic [DATA_W-1:0]       issue_rtdata;
    logic                    issue_ready;
    logic                    issue_done;
    logic [CNT_W-1:0]        count;
    logic                    almost_full;

    modport master (
        output flush, dispatch_en, dispatch_rdtag, dispatch_rstag, dispatch_rttag,
               dispatch_rsdata, dispatch_rtdata, dispatch_rsvalid, dispatch_rtvalid,
               cdb_tag, cdb_data, cdb_valid, issue_done,
        input  dispatch_ready, issue_rdtag, issue_rsdata, issue_rtdata, issue_ready,
               count, almost_full
    );

    modport slave (
        input  flush, dispatch_en, dispatch_rdtag, dispatch_rstag, dispatch_rttag,
               dispatch_rsdata, dispatch_rtdata, dispatch_rsvalid, dispatch_rtvalid,
               cdb_tag, cdb_data, cdb_valid, issue_done,
        output dispatch_ready, issue_rdtag, issue_rsdata, issue_rtdata, issue_ready,
               count, almost_full
    );

endinterface

// File: rtl/equeue_wake.sv
// One-operand CDB snooper: tag compare across all ports, lowest port wins.
module equeue_wake
    import equeue_pkg::*;
#(
    parameter int unsigned TAG_W  = DEF_TAG_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned N_CDB  = DEF_N_CDB
) (
    input  logic                    op_valid_i,
    input  logic [TAG_W-1:0]        op_tag_i,
    input  logic [DATA_W-1:0]       op_data_i,
    input  logic [N_CDB*TAG_W-1:0]  cdb_tag_i,
    input  logic [N_CDB*DATA_W-1:0] cdb_data_i,
    input  logic [N_CDB-1:0]        cdb_valid_i,
    output logic                    valid_c_o,
    output logic [DATA_W-1:0]       data_c_o,
    output logic                    multi_c_o
);

    // Resolved operands are never overwritten; a second matching port is only flagged.
    always_comb begin
        valid_c_o = op_valid_i;
        data_c_o  = op_data_i;
        multi_c_o = 1'b0;
        if (!op_valid_i) begin
            for (int k = 0; k < int'(N_CDB); k++) begin
                if (cdb_valid_i[k] && (cdb_tag_i[k*TAG_W +: TAG_W] == op_tag_i)) begin
                    if (valid_c_o) begin
                        multi_c_o = 1'b1;
                    end else begin
                        valid_c_o = 1'b1;
                        data_c_o  = cdb_data_i[k*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/equeue_gen.sv
// In-order-aging issue queue: compacting slots, multi-CDB wakeup, oldest-ready issue.
module equeue_gen
    import equeue_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned TAG_W  = DEF_TAG_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned N_CDB  = DEF_N_CDB,
    parameter int unsigned AFULL  = DEF_AFULL
) (
    input  logic    clk,
    input  logic    reset,
    equeue_if.slave q
);
    localparam int unsigned CNT_W = clog2(DEPTH + 1);
    localparam int unsigned IDX_W = clog2(DEPTH);

    logic              valid_q  [DEPTH];
    logic              valid_d  [DEPTH];
    logic              rsv_q    [DEPTH];
    logic              rsv_d    [DEPTH];
    logic              rtv_q    [DEPTH];
    logic              rtv_d    [DEPTH];
    logic [TAG_W-1:0]  rdtag_q  [DEPTH];
    logic [TAG_W-1:0]  rdtag_d  [DEPTH];
    logic [TAG_W-1:0]  rstag_q  [DEPTH];
    logic [TAG_W-1:0]  rstag_d  [DEPTH];
    logic [TAG_W-1:0]  rttag_q  [DEPTH];
    logic [TAG_W-1:0]  rttag_d  [DEPTH];
    logic [DATA_W-1:0] rsdata_q [DEPTH];
    logic [DATA_W-1:0] rsdata_d [DEPTH];
    logic [DATA_W-1:0] rtdata_q [DEPTH];
    logic [DATA_W-1:0] rtdata_d [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic              afull_q, afull_d;

    // Woken view of every slot, plus an empty sentinel at index DEPTH for the top shift.
    logic              w_valid [DEPTH+1];
    logic              w_rsv   [DEPTH+1];
    logic              w_rtv   [DEPTH+1];
    logic [TAG_W-1:0]  w_rd    [DEPTH+1];
    logic [TAG_W-1:0]  w_rs    [DEPTH+1];
    logic [TAG_W-1:0]  w_rt    [DEPTH+1];
    logic [DATA_W-1:0] w_rsd   [DEPTH+1];
    logic [DATA_W-1:0] w_rtd   [DEPTH+1];
    logic              rs_multi [DEPTH];
    logic              rt_multi [DEPTH];

    logic              in_rsv, in_rtv, in_rs_multi, in_rt_multi;
    logic [DATA_W-1:0] in_rsd, in_rtd;

    logic [IDX_W-1:0]  sel;
    logic              any_ready;
    logic              full, remove, push, disp_ready;
    logic [CNT_W-1:0]  push_idx;
    logic              shift [DEPTH];
    logic              multi_any;

    // Per-slot operand wakeup.
    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_slot
        equeue_wake #(.TAG_W(TAG_W), .DATA_W(DATA_W), .N_CDB(N_CDB)) u_rs (
            .op_valid_i (rsv_q[i]),     .op_tag_i   (rstag_q[i]), .op_data_i (rsdata_q[i]),
            .cdb_tag_i  (q.cdb_tag),    .cdb_data_i (q.cdb_data), .cdb_valid_i (q.cdb_valid),
            .valid_c_o  (w_rsv[i]),     .data_c_o   (w_rsd[i]),   .multi_c_o (rs_multi[i])
        );
        equeue_wake #(.TAG_W(TAG_W), .DATA_W(DATA_W), .N_CDB(N_CDB)) u_rt (
            .op_valid_i (rtv_q[i]),     .op_tag_i   (rttag_q[i]), .op_data_i (rtdata_q[i]),
            .cdb_tag_i  (q.cdb_tag),    .cdb_data_i (q.cdb_data), .cdb_valid_i (q.cdb_valid),
            .valid_c_o  (w_rtv[i]),     .data_c_o   (w_rtd[i]),   .multi_c_o (rt_multi[i])
        );
        assign w_valid[i] = valid_q[i];
        assign w_rd[i]    = rdtag_q[i];
        assign w_rs[i]    = rstag_q[i];
        assign w_rt[i]    = rttag_q[i];
    end

    assign w_valid[DEPTH] = 1'b0;
    assign w_rsv[DEPTH]   = 1'b0;
    assign w_rtv[DEPTH]   = 1'b0;
    assign w_rd[DEPTH]    = '0;
    assign w_rs[DEPTH]    = '0;
    assign w_rt[DEPTH]    = '0;
    assign w_rsd[DEPTH]   = '0;
    assign w_rtd[DEPTH]   = '0;

    // Bypass wakeup for the instruction being dispatched this cycle.
    equeue_wake #(.TAG_W(TAG_W), .DATA_W(DATA_W), .N_CDB(N_CDB)) u_in_rs (
        .op_valid_i (q.dispatch_rsvalid), .op_tag_i (q.dispatch_rstag), .op_data_i (q.dispatch_rsdata),
        .cdb_tag_i  (q.cdb_tag), .cdb_data_i (q.cdb_data), .cdb_valid_i (q.cdb_valid),
        .valid_c_o  (in_rsv), .data_c_o (in_rsd), .multi_c_o (in_rs_multi)
    );
    equeue_wake #(.TAG_W(TAG_W), .DATA_W(DATA_W), .N_CDB(N_CDB)) u_in_rt (
        .op_valid_i (q.dispatch_rtvalid), .op_tag_i (q.dispatch_rttag), .op_data_i (q.dispatch_rtdata),
        .cdb_tag_i  (q.cdb_tag), .cdb_data_i (q.cdb_data), .cdb_valid_i (q.cdb_valid),
        .valid_c_o  (in_rtv), .data_c_o (in_rtd), .multi_c_o (in_rt_multi)
    );

    // Oldest-ready select: first one from slot 0, using registered operand state only.
    always_comb begin
        sel       = '0;
        any_ready = 1'b0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (valid_q[i] && rsv_q[i] && rtv_q[i]) begin
                sel       = IDX_W'(i);
                any_ready = 1'b1;
            end
        end
    end

    assign q.issue_rdtag    = rdtag_q[sel];
    assign q.issue_rsdata   = rsdata_q[sel];
    assign q.issue_rtdata   = rtdata_q[sel];
    assign q.issue_ready    = any_ready;
    assign q.dispatch_ready = disp_ready;
    assign q.count          = count_q;
    assign q.almost_full    = afull_q;

    // Handshake decode and compaction vector (prefix-OR of empty-or-removed).
    always_comb begin
        logic hole;
        full       = (count_q == CNT_W'(DEPTH));
        remove     = q.issue_done & any_ready & ~q.flush;
        disp_ready = ~full | (q.issue_done & any_ready);
        push       = q.dispatch_en & disp_ready & ~q.flush;
        push_idx   = count_q - CNT_W'(remove);
        hole       = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            hole     = hole | ~valid_q[i] | (remove & (sel == IDX_W'(i)));
            shift[i] = hole;
        end
    end

    // Next slot contents: shifted/woken entry, then push into the first free slot, then flush.
    always_comb begin
        count_d = count_q;
        afull_d = afull_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            int j;
            j           = shift[i] ? i + 1 : i;
            valid_d[i]  = w_valid[j];
            rsv_d[i]    = w_rsv[j];
            rtv_d[i]    = w_rtv[j];
            rdtag_d[i]  = w_rd[j];
            rstag_d[i]  = w_rs[j];
            rttag_d[i]  = w_rt[j];
            rsdata_d[i] = w_rsd[j];
            rtdata_d[i] = w_rtd[j];
            if (push && (push_idx == CNT_W'(i))) begin
                valid_d[i]  = 1'b1;
                rsv_d[i]    = in_rsv;
                rtv_d[i]    = in_rtv;
                rdtag_d[i]  = q.dispatch_rdtag;
                rstag_d[i]  = q.dispatch_rstag;
                rttag_d[i]  = q.dispatch_rttag;
                rsdata_d[i] = in_rsd;
                rtdata_d[i] = in_rtd;
            end
            if (q.flush) begin
                valid_d[i] = 1'b0;
            end
        end
        if (q.flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(push) - CNT_W'(remove);
        end
        afull_d = ((DEPTH - 32'(count_d)) <= AFULL);
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                valid_q[i]  <= 1'b0;
                rsv_q[i]    <= 1'b0;
                rtv_q[i]    <= 1'b0;
                rdtag_q[i]  <= '0;
                rstag_q[i]  <= '0;
                rttag_q[i]  <= '0;
                rsdata_q[i] <= '0;
                rtdata_q[i] <= '0;
            end
            count_q <= '0;
            afull_q <= (DEPTH <= AFULL);
        end else begin
            valid_q  <= valid_d;
            rsv_q    <= rsv_d;
            rtv_q    <= rtv_d;
            rdtag_q  <= rdtag_d;
            rstag_q  <= rstag_d;
            rttag_q  <= rttag_d;
            rsdata_q <= rsdata_d;
            rtdata_q <= rtdata_d;
            count_q  <= count_d;
            afull_q  <= afull_d;
        end
    end

    // Two CDB ports carrying the same tag for a live operand is a producer protocol error.
    always_comb begin
        multi_any = q.dispatch_en & (in_rs_multi | in_rt_multi);
        for (int i = 0; i < int'(DEPTH); i++) begin
            multi_any = multi_any | (valid_q[i] & (rs_multi[i] | rt_multi[i]));
        end
    end

    a_cdb_unique : assert property (@(posedge clk) disable iff (!reset) !multi_any);

endmodule

// File: tb/tb_equeue_gen.sv
// Directed plus random bench for equeue_gen against an age-ordered queue model.
module tb_equeue_gen;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam int N_CDB  = 2;
    localparam int AFULL  = 1;

    typedef struct {
        logic [TAG_W-1:0]  rd, rs, rt;
        logic              rsv, rtv;
        logic [DATA_W-1:0] rsd, rtd;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    ent_t mq[$];

    equeue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .N_CDB(N_CDB)) qi ();

    equeue_gen #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .N_CDB(N_CDB), .AFULL(AFULL)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (qi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        qi.flush = 1'b0;        qi.dispatch_en = 1'b0;
        qi.dispatch_rdtag = '0; qi.dispatch_rstag = '0; qi.dispatch_rttag = '0;
        qi.dispatch_rsdata = '0; qi.dispatch_rtdata = '0;
        qi.dispatch_rsvalid = 1'b0; qi.dispatch_rtvalid = 1'b0;
        qi.cdb_tag = '0; qi.cdb_data = '0; qi.cdb_valid = '0;
        qi.issue_done = 1'b0;
    endtask

    task automatic set_disp(input logic [TAG_W-1:0] rd, input logic [TAG_W-1:0] rs,
                            input logic [TAG_W-1:0] rt, input logic rsv, input logic rtv,
                            input logic [DATA_W-1:0] rsd, input logic [DATA_W-1:0] rtd);
        qi.dispatch_en = 1'b1;
        qi.dispatch_rdtag = rd; qi.dispatch_rstag = rs; qi.dispatch_rttag = rt;
        qi.dispatch_rsvalid = rsv; qi.dispatch_rtvalid = rtv;
        qi.dispatch_rsdata = rsd; qi.dispatch_rtdata = rtd;
    endtask

    task automatic cdb(input int k, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        qi.cdb_valid[k] = 1'b1;
        qi.cdb_tag[k*TAG_W +: TAG_W] = tag;
        qi.cdb_data[k*DATA_W +: DATA_W] = data;
    endtask

    // A pending operand picks up the first broadcasting port whose tag matches.
    function automatic ent_t wake_ent(input ent_t e);
        ent_t r;
        r = e;
        for (int k = 0; k < N_CDB; k++) begin
            if (qi.cdb_valid[k]) begin
                if (!r.rsv && r.rs == qi.cdb_tag[k*TAG_W +: TAG_W]) begin
                    r.rsv = 1'b1; r.rsd = qi.cdb_data[k*DATA_W +: DATA_W];
                end
                if (!r.rtv && r.rt == qi.cdb_tag[k*TAG_W +: TAG_W]) begin
                    r.rtv = 1'b1; r.rtd = qi.cdb_data[k*DATA_W +: DATA_W];
                end
            end
        end
        return r;
    endfunction

    // Compare outputs with the model, advance the model, then cross one clock edge.
    task automatic cycle();
        int   sel;
        logic rdy, dr;
        ent_t e;
        #1;
        sel = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (sel < 0 && mq[i].rsv && mq[i].rtv) sel = i;
        end
        rdy = (sel >= 0);
        dr  = (mq.size() < DEPTH) || (qi.issue_done && rdy);
        chk("count", 64'(qi.count), 64'(mq.size()));
        chk("almost_full", 64'(qi.almost_full), 64'((DEPTH - mq.size()) <= AFULL));
        chk("dispatch_ready", 64'(qi.dispatch_ready), 64'(dr));
        chk("issue_ready", 64'(qi.issue_ready), 64'(rdy));
        if (rdy) begin
            chk("issue_rdtag", 64'(qi.issue_rdtag), 64'(mq[sel].rd));
            chk("issue_rsdata", 64'(qi.issue_rsdata), 64'(mq[sel].rsd));
            chk("issue_rtdata", 64'(qi.issue_rtdata), 64'(mq[sel].rtd));
        end else if (mq.size() > 0) begin
            chk("head_rdtag", 64'(qi.issue_rdtag), 64'(mq[0].rd));
        end
        if (qi.flush) begin
            mq.delete();
        end else begin
            if (qi.issue_done && rdy) mq.delete(sel);
            for (int i = 0; i < mq.size(); i++) mq[i] = wake_ent(mq[i]);
            if (qi.dispatch_en && dr) begin
                e.rd = qi.dispatch_rdtag; e.rs = qi.dispatch_rstag; e.rt = qi.dispatch_rttag;
                e.rsv = qi.dispatch_rsvalid; e.rtv = qi.dispatch_rtvalid;
                e.rsd = qi.dispatch_rsdata; e.rtd = qi.dispatch_rtdata;
                mq.push_back(wake_ent(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] t0, t1;
        idle();
        #1 reset = 1'b0;
        #1;
        chk("reset_count", 64'(qi.count), 64'd0);
        chk("reset_issue_ready", 64'(qi.issue_ready), 64'd0);
        chk("reset_dispatch_ready", 64'(qi.dispatch_ready), 64'd1);
        chk("reset_almost_full", 64'(qi.almost_full), 64'd0);
        #10 reset = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset with three resident entries
        for (int i = 0; i < 3; i++) begin
            set_disp(TAG_W'(40 + i), '0, '0, 1'b1, 1'b1, DATA_W'(i), DATA_W'(i + 8));
            cycle();
        end
        idle();
        #1;
        chk("pre_reset_count", 64'(qi.count), 64'd3);
        reset = 1'b0;
        #1;
        chk("async_count", 64'(qi.count), 64'd0);
        chk("async_issue_ready", 64'(qi.issue_ready), 64'd0);
        chk("async_dispatch_ready", 64'(qi.dispatch_ready), 64'd1);
        mq.delete();
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // Fill to full, try a dropped push, then push+issue and drain in age order
        for (int i = 1; i <= 4; i++) begin
            set_disp(TAG_W'(i), '0, '0, 1'b1, 1'b1, DATA_W'(32'h100 + i), DATA_W'(32'h200 + i));
            cycle();
        end
        idle();
        #1;
        chk("full_count", 64'(qi.count), 64'd4);
        chk("full_dispatch_ready", 64'(qi.dispatch_ready), 64'd0);
        chk("full_almost_full", 64'(qi.almost_full), 64'd1);
        set_disp(6'd9, '0, '0, 1'b1, 1'b1, 32'h9, 32'h9);
        cycle();
        set_disp(6'd5, '0, '0, 1'b1, 1'b1, 32'h105, 32'h205);
        qi.issue_done = 1'b1;
        #1;
        chk("order_1", 64'(qi.issue_rdtag), 64'd1);
        chk("push_issue_ready", 64'(qi.dispatch_ready), 64'd1);
        cycle();
        idle();
        qi.issue_done = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            #1;
            chk("order_n", 64'(qi.issue_rdtag), 64'(k));
            cycle();
        end
        idle();
        cycle();

        // Older pending entry is bypassed, then woken from CDB port 1
        set_disp(6'd10, 6'd9, '0, 1'b0, 1'b1, '0, 32'h55);
        cycle();
        set_disp(6'd11, '0, '0, 1'b1, 1'b1, 32'h11, 32'h22);
        cycle();
        idle();
        qi.issue_done = 1'b1;
        #1;
        chk("t3_younger_first", 64'(qi.issue_rdtag), 64'd11);
        cycle();
        idle();
        cdb(1, 6'd9, 32'hDEAD);
        #1;
        chk("t3_not_same_cycle", 64'(qi.issue_ready), 64'd0);
        cycle();
        idle();
        #1;
        chk("t3_ready", 64'(qi.issue_ready), 64'd1);
        chk("t3_rsdata", 64'(qi.issue_rsdata), 64'hDEAD);
        qi.issue_done = 1'b1;
        cycle();
        idle();
        cycle();

        // Dispatch bypass wakeup
        set_disp(6'd12, 6'd7, '0, 1'b0, 1'b1, '0, 32'h77);
        cdb(0, 6'd7, 32'h1234);
        cycle();
        idle();
        #1;
        chk("t4_ready", 64'(qi.issue_ready), 64'd1);
        chk("t4_rsdata", 64'(qi.issue_rsdata), 64'h1234);
        qi.issue_done = 1'b1;
        cycle();
        idle();
        cycle();

        // Both operands woken by different ports in one cycle
        set_disp(6'd13, 6'd20, 6'd21, 1'b0, 1'b0, '0, '0);
        cycle();
        idle();
        cdb(0, 6'd20, 32'hA5A5);
        cdb(1, 6'd21, 32'h5A5A);
        cycle();
        idle();
        #1;
        chk("t5_ready", 64'(qi.issue_ready), 64'd1);
        chk("t5_rsdata", 64'(qi.issue_rsdata), 64'hA5A5);
        chk("t5_rtdata", 64'(qi.issue_rtdata), 64'h5A5A);
        qi.issue_done = 1'b1;
        cycle();
        idle();
        cycle();

        // Flush overrides push and issue
        for (int i = 0; i < 3; i++) begin
            set_disp(TAG_W'(30 + i), '0, '0, 1'b1, 1'b1, DATA_W'(i), DATA_W'(i));
            cycle();
        end
        set_disp(6'd33, '0, '0, 1'b1, 1'b1, 32'h1, 32'h2);
        qi.issue_done = 1'b1;
        qi.flush = 1'b1;
        cycle();
        idle();
        #1;
        chk("t6_count", 64'(qi.count), 64'd0);
        chk("t6_issue_ready", 64'(qi.issue_ready), 64'd0);
        cycle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            if ($urandom_range(3, 0) != 0) begin
                set_disp(TAG_W'($urandom), TAG_W'($urandom_range(15, 0)), TAG_W'($urandom_range(15, 0)),
                         1'($urandom), 1'($urandom), DATA_W'($urandom), DATA_W'($urandom));
            end
            t0 = 4'($urandom_range(15, 0));
            t1 = t0 + 4'($urandom_range(15, 1));
            if ($urandom_range(1, 0) != 0) cdb(0, TAG_W'(t0), DATA_W'($urandom));
            if ($urandom_range(1, 0) != 0) cdb(1, TAG_W'(t1), DATA_W'($urandom));
            qi.issue_done = 1'($urandom);
            if ($urandom_range(31, 0) == 0) begin
                qi.flush = 1'b1;
                qi.issue_done = 1'b0;
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
